// File: rtl/trace_scheduler.sv
// -----------------------------------------------------------------------------
// trace_scheduler
//
// Frame-level sequencer and port arbiter for the trace buffer. On the rising
// edge of vblank it walks the tracer across the screen columns with a
// start/done handshake, commits each result to the trace buffer, and replaces
// a column whose tracer never answers with a dead (height 0) entry. Outside
// tracing, the buffer address is handed to the display read path.
//
// Optional feature (compile-time macro): TRACE_SCHED_INTERLACE_EN
//   When defined, each vblank traces only half the columns, alternating even
//   and odd columns frame to frame.
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   vblank      trace window (high outside visible rows)
//   visible     display is in the visible region
//   h           display column for buffer reads
//   trc_start   one-cycle pulse, tracer begins column trc_column
//   trc_column  column currently assigned to the tracer
//   trc_done    one-cycle pulse, tracer result valid
//   trc_side    wall side from tracer
//   trc_height  wall half-height from tracer
//   buf_column  trace buffer address (h while visible, else current column)
//   buf_we      trace buffer write enable
//   buf_side    trace buffer write data, side
//   buf_height  trace buffer write data, height
//   busy        high in START, WAIT or STORE
//   frame_ok    last frame traced every column with no timeout or abort
//   timeouts    saturating count of timed-out columns in current/last frame
// -----------------------------------------------------------------------------
module trace_scheduler #(
  parameter int COLUMNS = 640,
  parameter int COLW    = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            vblank,
  input  logic            visible,
  input  logic [COLW-1:0] h,
  output logic            trc_start,
  output logic [COLW-1:0] trc_column,
  input  logic            trc_done,
  input  logic            trc_side,
  input  logic [7:0]      trc_height,
  output logic [COLW-1:0] buf_column,
  output logic            buf_we,
  output logic            buf_side,
  output logic [7:0]      buf_height,
  output logic            busy,
  output logic            frame_ok,
  output logic [7:0]      timeouts
);

  localparam int            TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_STORE,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [COLW-1:0] column_q, column_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            vblank_q;
  logic [7:0]      timeouts_q, timeouts_d;
  logic            frame_ok_q, frame_ok_d;
  logic            side_q, side_d;
  logic [7:0]      height_q, height_d;
  logic            abort;
  logic            frame_end;  // leaving a frame, either from DONE or by abort

  // Column walk: first column, stride and last column of one pass.
  logic [COLW-1:0] first_col;
  logic [COLW-1:0] last_col;

`ifdef TRACE_SCHED_INTERLACE_EN
  localparam logic [COLW-1:0] STEP = COLW'(2);
  logic parity_q;  // 0: even columns this frame, 1: odd columns

  assign first_col = {{(COLW-1){1'b0}}, parity_q};
  assign last_col  = COLW'(COLUMNS - 2) + first_col;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_q ^ frame_end;
    end
  end
`else
  localparam logic [COLW-1:0] STEP = COLW'(1);

  assign first_col = '0;
  assign last_col  = COLW'(COLUMNS - 1);
`endif

  // Losing vblank mid-trace abandons the frame; it overrides every other
  // transition in the active states.
  assign abort = !vblank && (state_q inside {S_START, S_WAIT, S_STORE});

  // NOTE: every variable gets its default before the case statement, so no
  // path through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    column_d   = column_q;
    timer_d    = timer_q;
    timeouts_d = timeouts_q;
    frame_ok_d = frame_ok_q;
    side_d     = side_q;
    height_d   = height_q;
    frame_end  = 1'b0;

    if (abort) begin
      state_d    = S_IDLE;
      frame_ok_d = 1'b0;
      frame_end  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (vblank && !vblank_q) begin
            timeouts_d = '0;
            column_d   = first_col;
            state_d    = S_START;
          end
        end

        S_START: begin
          timer_d = '0;
          state_d = S_WAIT;
        end

        S_WAIT: begin
          // A result arriving on the timeout cycle still counts as a result.
          if (trc_done) begin
            side_d   = trc_side;
            height_d = trc_height;
            state_d  = S_STORE;
          end else if (timer_q == TIMEOUT_V) begin
            side_d   = 1'b0;
            height_d = 8'd0;
            if (timeouts_q != 8'hFF) begin
              timeouts_d = timeouts_q + 8'd1;
            end
            state_d  = S_STORE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end

        S_STORE: begin
          if (column_q == last_col) begin
            frame_ok_d = (timeouts_q == 8'd0);
            state_d    = S_DONE;
          end else begin
            column_d = column_q + STEP;
            state_d  = S_START;
          end
        end

        S_DONE: begin
          if (!vblank) begin
            frame_end = 1'b1;
            state_d   = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      column_q   <= '0;
      timer_q    <= '0;
      vblank_q   <= 1'b0;
      timeouts_q <= 8'd0;
      frame_ok_q <= 1'b0;
      side_q     <= 1'b0;
      height_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      column_q   <= column_d;
      timer_q    <= timer_d;
      vblank_q   <= vblank;
      timeouts_q <= timeouts_d;
      frame_ok_q <= frame_ok_d;
      side_q     <= side_d;
      height_q   <= height_d;
    end
  end

  assign trc_start  = (state_q == S_START);
  assign trc_column = column_q;
  assign busy       = (state_q inside {S_START, S_WAIT, S_STORE});
  // Qualifying with vblank keeps the aborting STORE cycle from writing.
  assign buf_we     = (state_q == S_STORE) && vblank;
  assign buf_column = visible ? h : column_q;
  assign buf_side   = side_q;
  assign buf_height = height_q;
  assign frame_ok   = frame_ok_q;
  assign timeouts   = timeouts_q;

endmodule

// File: tb/tb_trace_scheduler.sv
// -----------------------------------------------------------------------------
// tb_trace_scheduler
//
// Self-checking bench for trace_scheduler. A tracer model answers each
// trc_start after a per-column delay taken from delay_tab (0 = never answers).
// Before each frame, the bench derives the list of buffer writes the frame
// must produce directly from the column walk and the timeout rule; a monitor
// compares every buffer write, tracer start and display-read address against
// it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_trace_scheduler;

  localparam int COLUMNS      = 640;
  localparam int COLW         = 10;
  localparam int TIMEOUT      = 1023;
  localparam int FRAME_BUDGET = 20000;
`ifdef TRACE_SCHED_INTERLACE_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            vblank;
  logic            visible;
  logic [COLW-1:0] h;
  logic            trc_start;
  logic [COLW-1:0] trc_column;
  logic            trc_done;
  logic            trc_side;
  logic [7:0]      trc_height;
  logic [COLW-1:0] buf_column;
  logic            buf_we;
  logic            buf_side;
  logic [7:0]      buf_height;
  logic            busy;
  logic            frame_ok;
  logic [7:0]      timeouts;

  logic tr_done;    // tracer model answer
  logic spur_done;  // stray pulse injected outside tracing
  assign trc_done = tr_done | spur_done;

  typedef struct {
    int         col;
    logic       side;
    logic [7:0] height;
  } wr_t;

  wr_t        exp_q[$];
  int         delay_tab[COLUMNS];
  logic [7:0] salt;
  int         checks;
  int         errors;
  int         n_start;
  int         first;
  bit         parity;

  trace_scheduler #(
    .COLUMNS(COLUMNS),
    .COLW   (COLW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .vblank    (vblank),
    .visible   (visible),
    .h         (h),
    .trc_start (trc_start),
    .trc_column(trc_column),
    .trc_done  (trc_done),
    .trc_side  (trc_side),
    .trc_height(trc_height),
    .buf_column(buf_column),
    .buf_we    (buf_we),
    .buf_side  (buf_side),
    .buf_height(buf_height),
    .busy      (busy),
    .frame_ok  (frame_ok),
    .timeouts  (timeouts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Tracer result for a column (the salt varies the data between frames).
  function automatic logic [7:0] hgt(input int c);
    logic [7:0] v;
    v = c[7:0];
    return v ^ salt;
  endfunction

  function automatic logic sde(input int c);
    return c[0] ^ salt[7];
  endfunction

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tracer model: answers delay_tab[col] cycles after seeing trc_start.
  initial begin
    int cd;
    int col;
    tr_done    = 1'b0;
    trc_side   = 1'b0;
    trc_height = 8'd0;
    cd  = 0;
    col = 0;
    forever begin
      tick();
      tr_done = 1'b0;
      if (!reset) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            tr_done    = 1'b1;
            trc_side   = sde(col);
            trc_height = hgt(col);
          end
        end
        if (trc_start) begin
          col = int'(trc_column);
          cd  = delay_tab[col];
        end
      end
    end
  end

  // Monitor: tracer starts, buffer writes, display address mux.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (trc_start) begin
          check("start_col", trc_column, first + STEP * n_start);
          n_start++;
        end
        if (buf_we) begin
          check("we_while_visible", visible, 1'b0);
          check("wr_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_col", buf_column, e.col);
            check("wr_height", buf_height, e.height);
            check("wr_side", buf_side, e.side);
          end
        end
        if (visible) check("mux_h", buf_column, h);
      end
    end
  end

  // Expected writes for one pass, stopping before stop_col (-1 = whole pass).
  task automatic build_exp(input int stop_col, output int exp_to, output int n_exp);
    wr_t e;
    first   = (STEP == 2) ? int'(parity) : 0;
    n_start = 0;
    exp_to  = 0;
    n_exp   = 0;
    exp_q.delete();
    for (int c = first; c < COLUMNS; c += STEP) begin
      if (stop_col >= 0 && c >= stop_col) break;
      e.col = c;
      if (delay_tab[c] == 0 || delay_tab[c] > TIMEOUT + 1) begin
        e.side   = 1'b0;
        e.height = 8'd0;
        exp_to++;
      end else begin
        e.side   = sde(c);
        e.height = hgt(c);
      end
      exp_q.push_back(e);
      n_exp++;
    end
  endtask

  task automatic run_frame(input int abort_col);
    int exp_to;
    int n_exp;
    bit ok;
    build_exp(abort_col, exp_to, n_exp);
    tick();
    vblank = 1'b1;
    ok = 1'b0;
    if (abort_col < 0) begin
      for (int i = 0; i < FRAME_BUDGET; i++) begin
        @(negedge clk);
        if (i > 2 && !busy) begin
          ok = 1'b1;
          break;
        end
      end
      check("frame_end", ok, 1'b1);
      check("frame_ok", frame_ok, exp_to == 0);
      check("timeouts", timeouts, (exp_to > 255) ? 255 : exp_to);
      check("wr_left", exp_q.size(), 0);
      repeat (5) tick();
      check("done_hold_starts", n_start, n_exp);
      check("done_hold_busy", busy, 1'b0);
      vblank = 1'b0;
      tick();
    end else begin
      for (int i = 0; i < FRAME_BUDGET; i++) begin
        @(negedge clk);
        if (trc_start && int'(trc_column) == abort_col) begin
          ok = 1'b1;
          break;
        end
      end
      check("abort_reach", ok, 1'b1);
      tick();
      tick();
      vblank = 1'b0;
      tick();
      @(negedge clk);
      check("abort_busy", busy, 1'b0);
      check("abort_frame_ok", frame_ok, 1'b0);
      check("abort_wr_left", exp_q.size(), 0);
      repeat (8) tick();
    end
    parity = ~parity;
  endtask

  task automatic visible_phase(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      visible = 1'b1;
      h = COLW'($urandom_range(0, COLUMNS - 1));
    end
    tick();
    visible = 1'b0;
  endtask

  task automatic set_delays(input int lo, input int hi);
    for (int c = 0; c < COLUMNS; c++) delay_tab[c] = $urandom_range(lo, hi);
  endtask

  initial begin
    int exp_to;
    int n_exp;
    int tgt;
    bit ok;
    logic [7:0] to_before;

    checks    = 0;
    errors    = 0;
    n_start   = 0;
    first     = 0;
    parity    = 1'b0;
    salt      = 8'd0;
    reset     = 1'b0;
    vblank    = 1'b0;
    visible   = 1'b0;
    h         = '0;
    spur_done = 1'b0;
    set_delays(5, 5);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_trc_start", trc_start, 1'b0);
    check("rst_buf_we", buf_we, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_ok", frame_ok, 1'b0);
    check("rst_timeouts", timeouts, 0);
    check("rst_buf_column", buf_column, 0);
    check("rst_buf_height", buf_height, 0);
    tick();
    reset = 1'b1;
    repeat (2) tick();

    // Full frame, tracer answers 5 cycles after each start, height = column.
    run_frame(-1);
    visible_phase(40);

    // Abort while waiting on column 300; next frame restarts from the first column.
    salt = 8'($urandom);
    run_frame(300 + ((STEP == 2) ? int'(parity) : 0));
    salt = 8'($urandom);
    set_delays(1, 8);
    run_frame(-1);
    visible_phase(40);

    // Reset asserted while waiting on the third column of a frame.
    set_delays(5, 5);
    build_exp(-1, exp_to, n_exp);
    tgt = first + 2 * STEP;
    build_exp(tgt, exp_to, n_exp);
    tick();
    vblank = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < FRAME_BUDGET; i++) begin
      @(negedge clk);
      if (trc_start && int'(trc_column) == tgt) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_reach", ok, 1'b1);
    tick();
    tick();
    reset  = 1'b0;
    vblank = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_trc_start", trc_start, 1'b0);
    check("midrst_buf_we", buf_we, 1'b0);
    check("midrst_frame_ok", frame_ok, 1'b0);
    check("midrst_timeouts", timeouts, 0);
    check("midrst_wr_left", exp_q.size(), 0);
    parity = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();

    // Column 17 never answered: timeout, dead column, next column continues.
    salt = 8'($urandom);
    set_delays(1, 6);
    delay_tab[17] = 0;
    run_frame(-1);

    // Answer exactly on the timeout cycle wins; one cycle later times out.
    salt = 8'($urandom);
    set_delays(1, 6);
    delay_tab[(STEP == 2 ? int'(parity) : 0) + 5 * STEP] = TIMEOUT + 1;
    delay_tab[(STEP == 2 ? int'(parity) : 0) + 6 * STEP] = TIMEOUT + 2;
    run_frame(-1);

    // Stray trc_done while idle does nothing.
    to_before = timeouts;
    tick();
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("spur_busy", busy, 1'b0);
    check("spur_starts", n_start, exp_q.size() + n_start);
    check("spur_timeouts", timeouts, to_before);
    visible_phase(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_scheduler.md
Name: trace_scheduler

Overview:
Frame-level sequencer and port arbiter for the trace buffer. During vertical blanking it walks the tracer across every screen column with a start/done handshake. It commits each result to the trace buffer and times out stalled columns. Outside tracing it gives the buffer column address to the display read path.

Parameters:
COLUMNS, 640, number of screen columns traced per frame
COLW, 10, width of column addresses
TIMEOUT, 1023, max cycles to wait for trc_done per column

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (low = in reset)
vblank  in  1  high while outside visible rows; the trace window
visible  in  1  display in visible region
h  in  COLW  display column for buffer reads
trc_start  out  1  one-cycle pulse: tracer begins column trc_column
trc_column  out  COLW  column currently assigned to tracer
trc_done  in  1  one-cycle pulse: tracer result valid
trc_side  in  1  wall side from tracer
trc_height  in  8  wall half-height from tracer
buf_column  out  COLW  trace buffer address
buf_we  out  1  trace buffer write enable
buf_side  out  1  write data, side
buf_height  out  8  write data, height
busy  out  1  high in any state other than IDLE/DONE
frame_ok  out  1  last frame traced all columns with no timeout or abort
timeouts  out  8  saturating count of timed-out columns in the current/last frame

Behaviour:
- Reset (async assert, sync release): state IDLE, column=0, timer=0, vblank_q=0. All outputs 0, except buf_column, which follows the mux below.
- States: IDLE, START, WAIT, STORE, DONE.
- IDLE: when vblank=1 and vblank_q=0 (rising edge; vblank_q is vblank registered), clear timeouts and column=first column, then go to START. trc_start is high in the cycle after the edge is sampled.
- START: trc_start=1 for exactly one cycle, timer=0, then go to WAIT.
- WAIT: timer increments each cycle.
  - trc_done=1: latch trc_side/trc_height into buf_side/buf_height, then go to STORE.
  - Otherwise, if timer==TIMEOUT: buf_height=0, buf_side=0, timeouts+1 (saturating at 255), then go to STORE. This produces a deliberate dead (magenta) column.
  - trc_done in the same cycle as the timeout: trc_done wins and no timeout is counted.
- STORE: buf_we=1 for one cycle with buf_column=column.
  - If column is the last column: go to DONE, frame_ok <= (timeouts==0).
  - Otherwise: column advances and the FSM goes to START.
- DONE: hold until vblank=0, then go to IDLE.
- trc_done outside WAIT is ignored.
- Abort: if vblank=0 in START, WAIT or STORE, go to IDLE next cycle with frame_ok=0.
  - buf_we is forced 0 in that cycle; buf_we = (state==STORE) && vblank.
  - Columns already written stay written.
- Address mux: buf_column = visible ? h : column.
  - buf_we is never 1 while visible=1.
- trc_column = column at all times.
- Minimum per-column cost is 3 cycles (START, WAIT with immediate done, STORE).
- Column arithmetic is unsigned COLW-bit; column never exceeds COLUMNS-1.

Optional Feature:
TRACE_SCHED_INTERLACE_EN
- Defined: an internal parity bit (reset 0) selects even columns (parity 0) or odd columns (parity 1).
  - First column = parity; step = 2; last column = COLUMNS-2+parity.
  - Parity toggles on every exit from DONE or abort.
  - frame_ok reflects the half-frame just traced.
- Undefined: first column = 0, step = 1, last column = COLUMNS-1; no parity state.

Test Plan:
1. Reset low mid-WAIT -> next edge state IDLE, trc_start=0, buf_we=0, frame_ok=0, timeouts=0.
2. vblank rises, tracer model answers trc_done 5 cycles after each trc_start with height=column[7:0] -> exactly 640 buf_we pulses, at columns 0..639 in order, with matching heights; frame_ok=1; DONE is held until vblank falls.
3. Tracer ignores column 17 -> trc_done is absent for 1023 cycles, then column 17 is stored with height 0 and timeouts=1; column 18 starts next; frame_ok=0 at the end.
4. vblank falls while WAITing on column 300 -> no further buf_we, state IDLE, frame_ok=0; the next vblank restarts at column 0.
5. trc_done and timer==TIMEOUT coincide -> tracer data is stored and timeouts is unchanged; a spurious trc_done in IDLE is ignored.
6. With TRACE_SCHED_INTERLACE_EN: frame 1 writes columns 0,2..638 (320 writes) and frame 2 writes 1,3..639. Across all frames, buf_column==h whenever visible=1.
